// File: rtl/song_recorder_pkg.sv
// Shared constants, state encoding and key priority encoders for the song recorder.
// Track entries are packed {octave, note, length} to match the song ROM layout.
package song_recorder_pkg;

  localparam int ADDR_BITS       = 6;
  localparam int DEPTH           = 1 << ADDR_BITS;
  localparam int NOTE_KEY_BITS   = 7;
  localparam int LENGTH_KEY_BITS = 4;
  localparam int OCTAVE_BITS     = 3;
  localparam int NOTE_BITS       = 3;
  localparam int LENGTH_BITS     = 3;
  localparam int ENTRY_BITS      = OCTAVE_BITS + NOTE_BITS + LENGTH_BITS;

  localparam logic [NOTE_BITS-1:0] NOTE_REST = 3'd0;
  localparam logic [NOTE_BITS-1:0] NOTE_DO   = 3'd1;
  localparam logic [NOTE_BITS-1:0] NOTE_RE   = 3'd2;
  localparam logic [NOTE_BITS-1:0] NOTE_MI   = 3'd3;
  localparam logic [NOTE_BITS-1:0] NOTE_FA   = 3'd4;
  localparam logic [NOTE_BITS-1:0] NOTE_SOL  = 3'd5;
  localparam logic [NOTE_BITS-1:0] NOTE_LA   = 3'd6;
  localparam logic [NOTE_BITS-1:0] NOTE_SI   = 3'd7;

  localparam logic [OCTAVE_BITS-1:0] OCT_MIN     = 3'd1;
  localparam logic [OCTAVE_BITS-1:0] OCT_MAX     = 3'd7;
  localparam logic [OCTAVE_BITS-1:0] OCT_DEFAULT = 3'd4;

  localparam logic [LENGTH_BITS-1:0] LEN_KEY0    = 3'd1;
  localparam logic [LENGTH_BITS-1:0] LEN_KEY1    = 3'd2;
  localparam logic [LENGTH_BITS-1:0] LEN_KEY2    = 3'd3;
  localparam logic [LENGTH_BITS-1:0] LEN_KEY3    = 3'd4;
  localparam logic [LENGTH_BITS-1:0] DEFAULT_LEN = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_DONE = 2'd2
  } rec_state_t;

  // Lowest set key wins; the loop runs downward so the last assignment is the lowest bit.
  function automatic logic [NOTE_BITS-1:0] note_code(input logic [NOTE_KEY_BITS-1:0] keys);
    note_code = NOTE_REST;
    for (int i = NOTE_KEY_BITS - 1; i >= 0; i--) begin
      if (keys[i]) note_code = NOTE_BITS'(i + 1);
    end
  endfunction

  function automatic logic [LENGTH_BITS-1:0] length_code(input logic [LENGTH_KEY_BITS-1:0] keys);
    length_code = DEFAULT_LEN;
    for (int i = LENGTH_KEY_BITS - 1; i >= 0; i--) begin
      if (keys[i]) length_code = LENGTH_BITS'(i + 1);
    end
  endfunction

endpackage

// File: rtl/track_ram.sv
// Track memory: one write port and one registered read port with read-old-data behaviour.
// Contents are deliberately not reset; only the read register is.
module track_ram
  import song_recorder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [ENTRY_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [ENTRY_BITS-1:0] rd_data
);

  logic [ENTRY_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/song_recorder.sv
// Record-mode controller: turns note/rest key presses into track entries that
// the play-mode path can replay, with octave control, undo and finish.
module song_recorder
  import song_recorder_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       oct_up,
  input  logic                       oct_down,
  input  logic [NOTE_KEY_BITS-1:0]   note_key,
  input  logic [LENGTH_KEY_BITS-1:0] length_key,
  input  logic                       rest_key,
  input  logic                       undo,
  input  logic                       finish,
  input  logic [ADDR_BITS-1:0]       rd_addr,
  output logic [OCTAVE_BITS-1:0]     rd_octave,
  output logic [NOTE_BITS-1:0]       rd_note,
  output logic [LENGTH_BITS-1:0]     rd_length,
  output logic [ADDR_BITS:0]         track_len,
  output logic [OCTAVE_BITS-1:0]     octave,
  output logic [NOTE_BITS-1:0]       last_note,
  output logic                       recording,
  output logic                       full
);

  rec_state_t                 state;
  logic                       en_d;
  logic [NOTE_KEY_BITS-1:0]   key_prev;
  logic                       press;
  logic                       wr_en;
  logic [NOTE_BITS-1:0]       cap_note;
  logic [LENGTH_BITS-1:0]     cap_len;
  logic [ENTRY_BITS-1:0]      wr_data;
  logic [ENTRY_BITS-1:0]      rd_data;

  assign recording = (state == ST_REC);
  assign full      = (track_len == (ADDR_BITS+1)'(DEPTH));

  // A write needs every higher-priority event (en low, finish, undo) absent; a press shadows rest_key.
  always_comb begin
    press    = (note_key != '0) && (key_prev == '0);
    cap_len  = length_code(length_key);
    cap_note = press ? note_code(note_key) : NOTE_REST;
    wr_en    = 1'b0;
    if ((state == ST_REC) && en && !finish && !undo && !full && (press || rest_key))
      wr_en = 1'b1;
    wr_data  = {octave, cap_note, cap_len};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      en_d      <= 1'b0;
      key_prev  <= '0;
      track_len <= '0;
      octave    <= OCT_DEFAULT;
      last_note <= NOTE_REST;
    end else begin
      en_d     <= en;
      key_prev <= note_key;
      case (state)
        ST_IDLE: begin
          if (en && !en_d) begin
            state     <= ST_REC;
            track_len <= '0;
            last_note <= NOTE_REST;
            octave    <= OCT_DEFAULT;
          end
        end
        ST_REC: begin
          if (!en) begin
            state <= ST_IDLE;
          end else begin
            if (oct_up && !oct_down && (octave != OCT_MAX))
              octave <= octave + 3'd1;
            else if (oct_down && !oct_up && (octave != OCT_MIN))
              octave <= octave - 3'd1;

            if (finish) begin
              state <= ST_DONE;
            end else if (undo) begin
              if (track_len != '0) begin
                track_len <= track_len - 1'b1;
                last_note <= NOTE_REST;
              end
            end else if (wr_en) begin
              track_len <= track_len + 1'b1;
              last_note <= cap_note;
            end
          end
        end
        ST_DONE: begin
          if (!en) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  track_ram u_track_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .wr_addr (track_len[ADDR_BITS-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign {rd_octave, rd_note, rd_length} = rd_data;

endmodule

// File: tb/tb_song_recorder.sv
// Scoreboard bench for song_recorder: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_song_recorder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       oct_up = 1'b0, oct_down = 1'b0, rest_key = 1'b0, undo = 1'b0, finish = 1'b0;
  logic [6:0] note_key = '0;
  logic [3:0] length_key = '0;
  logic [5:0] rd_addr = '0;
  logic [2:0] rd_octave, rd_note, rd_length, octave, last_note;
  logic [6:0] track_len;
  logic       recording, full;

  typedef enum int {K_LEN, K_OCT, K_LAST, K_REC, K_FULL, K_RD} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_UP   = 5'b00001;
  localparam logic [4:0] P_DOWN = 5'b00010;
  localparam logic [4:0] P_REST = 5'b00100;
  localparam logic [4:0] P_UNDO = 5'b01000;
  localparam logic [4:0] P_FIN  = 5'b10000;

  song_recorder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .oct_up     (oct_up),
    .oct_down   (oct_down),
    .note_key   (note_key),
    .length_key (length_key),
    .rest_key   (rest_key),
    .undo       (undo),
    .finish     (finish),
    .rd_addr    (rd_addr),
    .rd_octave  (rd_octave),
    .rd_note    (rd_note),
    .rd_length  (rd_length),
    .track_len  (track_len),
    .octave     (octave),
    .last_note  (last_note),
    .recording  (recording),
    .full       (full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actualOf(input kind_t k);
    case (k)
      K_LEN:   actualOf = 32'(track_len);
      K_OCT:   actualOf = 32'(octave);
      K_LAST:  actualOf = 32'(last_note);
      K_REC:   actualOf = 32'(recording);
      K_FULL:  actualOf = 32'(full);
      default: actualOf = 32'({rd_octave, rd_note, rd_length});
    endcase
  endfunction

  // Monitor: every queued expectation is compared on the falling edge after it was pushed.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      sb_entry_t e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = actualOf(e.kind);
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic checkOutput(input kind_t k, input logic [31:0] exp, input string name);
    sb_entry_t e;
    e.kind = k;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic checkEntry(input logic [2:0] o, input logic [2:0] n, input logic [2:0] l,
                            input string name);
    checkOutput(K_RD, 32'({o, n, l}), name);
  endtask

  // Drives one clock of inputs; pulses are cleared just after the edge, key levels persist.
  task automatic applyStimulus(input logic [4:0] pulses, input logic [6:0] nk, input logic [3:0] lk);
    note_key   = nk;
    length_key = lk;
    {finish, undo, rest_key, oct_down, oct_up} = pulses;
    @(posedge clk);
    #1;
    {finish, undo, rest_key, oct_down, oct_up} = 5'b0;
  endtask

  task automatic pressKey(input logic [6:0] nk, input logic [3:0] lk);
    applyStimulus(P_NONE, nk, lk);
    applyStimulus(P_NONE, 7'd0, lk);
  endtask

  task automatic readAddr(input logic [5:0] a);
    rd_addr = a;
    applyStimulus(P_NONE, 7'd0, 4'd0);
  endtask

  initial begin
    $display("[TB] song_recorder scoreboard bench");
    #1;
    checkOutput(K_LEN,  0, "reset_track_len");
    checkOutput(K_OCT,  4, "reset_octave");
    checkOutput(K_LAST, 0, "reset_last_note");
    checkOutput(K_REC,  0, "reset_recording");
    checkOutput(K_FULL, 0, "reset_full");
    checkOutput(K_RD,   0, "reset_rd");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Enter record mode and capture one note.
    en = 1'b1;
    applyStimulus(P_NONE, 7'd0, 4'd0);
    checkOutput(K_REC, 1, "enter_rec");
    checkOutput(K_LEN, 0, "enter_len");
    applyStimulus(P_NONE, 7'b0000100, 4'b0010);
    checkOutput(K_LEN,  1, "first_press_len");
    checkOutput(K_LAST, 3, "first_press_last");
    for (int i = 0; i < 50; i++) applyStimulus(P_NONE, 7'b0000100, 4'b0010);
    checkOutput(K_LEN, 1, "hold_no_write");
    applyStimulus(P_NONE, 7'd0, 4'd0);
    readAddr(6'd0);
    checkEntry(3'd4, 3'd3, 3'd2, "mem0_first");

    // Octave saturation and simultaneous up/down.
    for (int i = 0; i < 4; i++) applyStimulus(P_UP, 7'd0, 4'd0);
    checkOutput(K_OCT, 7, "oct_saturate_hi");
    pressKey(7'b0000001, 4'd0);
    checkOutput(K_LEN, 2, "oct7_press_len");
    readAddr(6'd1);
    checkEntry(3'd7, 3'd1, 3'd2, "mem1_oct7");
    applyStimulus(P_UP | P_DOWN, 7'd0, 4'd0);
    checkOutput(K_OCT, 7, "oct_up_down_same");
    applyStimulus(P_DOWN, 7'd0, 4'd0);
    checkOutput(K_OCT, 6, "oct_down");

    // Fill the track to 64 entries, then overflow.
    for (int i = 0; i < 62; i++) pressKey(7'(1 << (i % 7)), 4'd0);
    checkOutput(K_LEN,  64, "fill_len");
    checkOutput(K_FULL, 1,  "fill_full");
    checkOutput(K_LAST, 6,  "fill_last");
    pressKey(7'b0000001, 4'b0001);
    checkOutput(K_LEN,  64, "overflow_len");
    checkOutput(K_FULL, 1,  "overflow_full");
    readAddr(6'd63);
    checkEntry(3'd6, 3'd6, 3'd2, "mem63_kept");
    readAddr(6'd0);
    checkEntry(3'd4, 3'd3, 3'd2, "mem0_not_wrapped");
    applyStimulus(P_UNDO, 7'd0, 4'd0);
    checkOutput(K_LEN,  63, "undo_from_full_len");
    checkOutput(K_FULL, 0,  "undo_from_full_full");
    checkOutput(K_LAST, 0,  "undo_last");

    // Re-enter record mode: track restarts, octave back to default.
    en = 1'b0;
    applyStimulus(P_NONE, 7'd0, 4'd0);
    checkOutput(K_REC, 0, "en_low_idle");
    checkOutput(K_LEN, 63, "idle_keeps_len");
    en = 1'b1;
    applyStimulus(P_NONE, 7'd0, 4'd0);
    checkOutput(K_LEN, 0, "reenter_len");
    checkOutput(K_OCT, 4, "reenter_oct");
    applyStimulus(P_UNDO, 7'd0, 4'd0);
    checkOutput(K_LEN, 0, "undo_at_zero");
    applyStimulus(P_REST, 7'b1000001, 4'b1000);
    checkOutput(K_LEN,  1, "press_rest_len");
    checkOutput(K_LAST, 1, "press_rest_note");
    applyStimulus(P_NONE, 7'd0, 4'd0);
    readAddr(6'd0);
    checkEntry(3'd4, 3'd1, 3'd4, "mem0_press_wins");
    applyStimulus(P_UNDO, 7'b0000010, 4'd0);
    checkOutput(K_LEN, 0, "undo_beats_press");
    applyStimulus(P_NONE, 7'd0, 4'd0);
    applyStimulus(P_REST, 7'd0, 4'b0100);
    checkOutput(K_LEN,  1, "rest_len");
    checkOutput(K_LAST, 0, "rest_note");
    readAddr(6'd0);
    checkEntry(3'd4, 3'd0, 3'd3, "mem0_rest");

    // Finish with a press writes nothing; DONE ignores captures.
    applyStimulus(P_FIN, 7'b0001000, 4'd0);
    checkOutput(K_LEN, 1, "finish_press_len");
    checkOutput(K_REC, 0, "done_not_rec");
    applyStimulus(P_NONE, 7'd0, 4'd0);
    pressKey(7'b0010000, 4'd0);
    checkOutput(K_LEN, 1, "done_frozen");
    en = 1'b0;
    rd_addr = 6'd0;
    applyStimulus(P_NONE, 7'd0, 4'd0);
    checkEntry(3'd4, 3'd0, 3'd3, "idle_read");
    checkOutput(K_LEN, 1, "idle_len_kept");
    en = 1'b1;
    applyStimulus(P_NONE, 7'd0, 4'd0);
    checkOutput(K_LEN, 0, "reraise_len");
    applyStimulus(P_UP, 7'd0, 4'd0);
    pressKey(7'b0100000, 4'd0);
    checkOutput(K_LEN,  1, "pre_reset_len");
    checkOutput(K_LAST, 6, "pre_reset_last");

    // Asynchronous reset between edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(K_LEN,  0, "async_len");
    checkOutput(K_OCT,  4, "async_oct");
    checkOutput(K_LAST, 0, "async_last");
    checkOutput(K_REC,  0, "async_rec");
    checkOutput(K_RD,   0, "async_rd");
    @(negedge clk);
    #1;
    en = 1'b0;
    rst_n = 1'b1;
    applyStimulus(P_NONE, 7'd0, 4'd0);
    checkOutput(K_REC, 0, "post_reset_idle");

    begin
      int budget = 5;
      while (sb.size() > 0 && budget > 0) begin
        @(negedge clk);
        #1;
        budget--;
      end
      if (sb.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL drain: %0d pending, expected 0", sb.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
